// File: rtl/dff_stim_pkg.sv
// Shared constants for the D-input stimulus sequencer: FSM state encoding
// and default widths.
package dff_stim_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int PAT_W_DEF  = 8;
    localparam int HOLD_W_DEF = 16;
    localparam int REP_W_DEF  = 4;
endpackage

// File: rtl/d_pattern_gen_if.sv
// Control/status bundle between the VIO/ILA side (master) and the pattern sequencer (slave).
interface d_pattern_gen_if #(
    parameter int PAT_W  = 8,
    parameter int HOLD_W = 16,
    parameter int REP_W  = 4
);
    localparam int IDX_W = $clog2(PAT_W);

    // Protocol: a rising edge on start while not busy launches one run; the
    // run parameters are captured on that edge, busy is high for the whole
    // run, and done stays high from run completion until the next start or abort.
    logic              start;
    logic              abort;
    logic [PAT_W-1:0]  pattern;
    logic [HOLD_W-1:0] hold_cycles;
    logic [REP_W-1:0]  passes;
    logic              d_out;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  bit_idx;
    logic [REP_W-1:0]  pass_cnt;
    logic [1:0]        fsm_state;

    modport master (
        output start, abort, pattern, hold_cycles, passes,
        input  d_out, busy, done, bit_idx, pass_cnt, fsm_state
    );

    modport slave (
        input  start, abort, pattern, hold_cycles, passes,
        output d_out, busy, done, bit_idx, pass_cnt, fsm_state
    );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector; RST_VAL sets the assumed previous level
// so a level already high at reset release is not reported as an edge.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) din_q <= RST_VAL;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;
endmodule

// File: rtl/d_pattern_gen.sv
// Serial stimulus sequencer: shifts a latched pattern LSB-first onto d_out,
// each bit held for hold_cycles clocks, repeated for a number of passes.
module d_pattern_gen
    import dff_stim_pkg::*;
#(
    parameter int PAT_W  = PAT_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int REP_W  = REP_W_DEF
) (
    input  logic            my_clk,
    input  logic            rst,
    d_pattern_gen_if.slave  bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(PAT_W - 1);

    logic              start_rise;
    logic [1:0]        state, state_nxt;
    logic [PAT_W-1:0]  pat_l;
    logic [HOLD_W-1:0] hold_l, hold_ctr;
    logic [REP_W-1:0]  pass_l, pass_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic              d_out_q;
    logic              launch, hold_end, bit_last, pass_last;

    rise_detect #(.RST_VAL(1'b1)) u_start_rise (
        .clk  (my_clk),
        .rst  (rst),
        .din  (bus.start),
        .rise (start_rise)
    );

    // A start edge while running is ignored; abort always beats start.
    always_comb begin
        launch    = start_rise & ~bus.abort & (state != ST_RUN);
        hold_end  = (hold_ctr == hold_l - HOLD_W'(1));
        bit_last  = (bit_idx == LAST_BIT);
        pass_last = (pass_cnt == pass_l - REP_W'(1));
    end

    always_ff @(posedge my_clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.abort)                          state_nxt = ST_IDLE;
                else if (hold_end && bit_last && pass_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.abort)   state_nxt = ST_IDLE;
                else if (launch) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Zero hold/pass requests are promoted to 1 when captured.
    always_ff @(posedge my_clk) begin
        if (rst) begin
            pat_l    <= '0;
            hold_l   <= '0;
            pass_l   <= '0;
            hold_ctr <= '0;
            bit_idx  <= '0;
            pass_cnt <= '0;
            d_out_q  <= 1'b0;
        end else if (launch) begin
            pat_l    <= bus.pattern;
            hold_l   <= (bus.hold_cycles == '0) ? HOLD_W'(1) : bus.hold_cycles;
            pass_l   <= (bus.passes == '0) ? REP_W'(1) : bus.passes;
            hold_ctr <= '0;
            bit_idx  <= '0;
            pass_cnt <= '0;
            d_out_q  <= bus.pattern[0];
        end else if (bus.abort && (state != ST_IDLE)) begin
            hold_ctr <= '0;
            bit_idx  <= '0;
            pass_cnt <= '0;
            d_out_q  <= 1'b0;
        end else if (state == ST_RUN) begin
            if (!hold_end) begin
                hold_ctr <= hold_ctr + HOLD_W'(1);
            end else begin
                hold_ctr <= '0;
                if (!bit_last) begin
                    bit_idx <= bit_idx + IDX_W'(1);
                    d_out_q <= pat_l[bit_idx + IDX_W'(1)];
                end else if (!pass_last) begin
                    bit_idx  <= '0;
                    pass_cnt <= pass_cnt + REP_W'(1);
                    d_out_q  <= pat_l[0];
                end else begin
                    d_out_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.busy      = (state == ST_RUN);
        bus.done      = (state == ST_DONE);
        bus.d_out     = d_out_q;
        bus.bit_idx   = bit_idx;
        bus.pass_cnt  = pass_cnt;
        bus.fsm_state = state;
    end
endmodule
